dk_sprite_fetch: RTL and testbench
==================================

// Module: dk_sprite_fetch
// PURPOSE
//  Sprite blitter front end. Walks one sprite in a synchronous palette-index ROM, row-major.
//  Emits one 4-bit palette index plus its screen coordinate per accepted pixel.
//  Feeds the 4-bit -> RGB565 palette lookup stage directly downstream.
//  Transparent and off-screen pixels are skipped before they reach the palette or the framebuffer.
// PARAMETERS
//  ROM_AW           16   sprite ROM address width
//  DIM_W            7    sprite width/height field width (max 127 px)
//  SCREEN_W         640  visible columns; pixels with x >= SCREEN_W are clipped
//  SCREEN_H         480  visible rows; pixels with y >= SCREEN_H are clipped
//  TRANSPARENT_IDX  0    palette index treated as transparent (background key colour)
// PORTS
//  Clk          in   1       system clock, rising edge
//  Reset        in   1       asynchronous, active-high reset
//  start        in   1       1-cycle request; sampled only in IDLE
//  sprite_base  in   ROM_AW  ROM address of sprite pixel (0,0); captured on start
//  pos_x        in   10      screen x of sprite left column; captured on start
//  pos_y        in   10      screen y of sprite top row; captured on start
//  spr_w        in   DIM_W   sprite width in pixels; captured on start
//  spr_h        in   DIM_W   sprite height in pixels; captured on start
//  flip_h       in   1       mirror horizontally; captured on start
//  rom_addr     out  ROM_AW  ROM read address; data returns exactly 1 cycle later
//  rom_data     in   4       palette index from ROM
//  pix_valid    out  1       pix_* outputs hold a pixel for downstream
//  pix_ready    in   1       downstream accepts when pix_valid && pix_ready
//  pix_index    out  4       palette index, passed on to the RGB565 lookup
//  pix_x        out  10      screen x of the emitted pixel
//  pix_y        out  10      screen y of the emitted pixel
//  busy         out  1       high from the cycle after start until done
//  done         out  1       1-cycle pulse when the sprite is finished
// BEHAVIOUR
//  Reset: all outputs 0 and FSM in IDLE. Reset is asynchronous and may occur in any state.
//   A reset mid-sprite abandons the sprite; no pixel or done pulse follows it.
//  FSM states and transitions:
//   IDLE: start=1 -> capture all inputs, row=col=0.
//     spr_w==0 or spr_h==0 -> DONE, otherwise -> FETCH.
//   FETCH: drive rom_addr, then -> WAIT.
//   WAIT: register rom_data.
//     Pixel is skipped if index==TRANSPARENT_IDX, or x>=SCREEN_W, or y>=SCREEN_H.
//     Skipped -> advance the pixel. Not skipped -> OUT.
//   OUT: pix_valid=1. All pix_* outputs stay stable until pix_ready=1.
//     On accept -> advance the pixel (valid falls in the next cycle unless re-asserted).
//   Advance: col+1. If col==spr_w-1: col=0, row+1.
//     If row==spr_h-1 at the end of a row -> DONE, otherwise -> FETCH.
//   DONE: done=1 for one cycle, busy=0, then -> IDLE.
//     start is accepted again in the IDLE cycle after that.
//  Address and width rules:
//   rom_col = flip_h ? spr_w-1-col : col.
//   rom_addr = sprite_base + row*spr_w + rom_col, taken modulo 2^ROM_AW.
//   Screen x = pos_x + col and y = pos_y + row, computed at 11 bits so the clip test sees overflow.
//   pix_x and pix_y are the low 10 bits of those sums.
//   Emitted pix_x/pix_y are always < SCREEN_W / SCREEN_H.
//  Timing: 3 cycles per pixel minimum (FETCH, WAIT, OUT with ready=1); a skipped pixel costs 2 cycles.
//  start while busy is ignored. busy=1 in FETCH, WAIT and OUT.
// STRUCTURE
//  Shared package dk_gfx_pkg holds:
//   - typedef pal_idx_t (logic [3:0])
//   - the fetch-FSM state enum
//   - the SCREEN_W and SCREEN_H constants
//   - TRANSPARENT_IDX, shared with the palette stage
//  No sub-module. The row*spr_w product is a registered row_base accumulator (+spr_w per row), not a multiplier.
// TESTING
//  1. 2x2 sprite, indices {1,2,3,4}, pos (10,20), ready=1 -> pixels (10,20,1) (11,20,2) (10,21,3) (11,21,4).
//     Then done pulses once; 12 cycles from FETCH of pixel 0 to DONE.
//  2. 3x1 sprite, indices {0,5,0} -> exactly one pixel (pos_x+1, pos_y, 5); both index-0 pixels skipped.
//  3. 4x1 sprite at pos_x=638, all opaque -> pixels x=638 and x=639 only; done follows.
//  4. flip_h=1, 3x1 sprite, indices {7,8,9} -> emitted x order pos_x, +1, +2 carries indices 9, 8, 7.
//  5. ready held low for 5 cycles in OUT -> valid, index, x and y constant throughout; pixel accepted once.
//  6. Reset asserted in WAIT of a 4x4 sprite -> all outputs 0 at once, no done pulse.
//     A new start is then accepted normally. Also: spr_w=0 -> done 1 cycle after start, no pixels emitted.

Source files
------------

// File: rtl/dk_gfx_pkg.sv
// dk_gfx_pkg
//   Shared definitions for the sprite blitter and the palette stage that
//   follows it.
//   - pal_idx_t       : 4-bit palette index carried between the stages
//   - fetch_state_t   : state encoding of the sprite fetch FSM; it is also
//                       visible on dk_sprite_fetch.dbg_state
//   - SCREEN_W/H      : visible area. Pixels at or beyond it are clipped.
//   - TRANSPARENT_IDX : background key colour. It is never drawn.
package dk_gfx_pkg;

    typedef logic [3:0] pal_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } fetch_state_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    localparam pal_idx_t TRANSPARENT_IDX = 4'd0;

endpackage

// File: rtl/dk_sprite_fetch.sv
// dk_sprite_fetch
//   Sprite blitter front end. It walks one sprite in a synchronous
//   palette-index ROM in row-major order. For every visible, opaque pixel it
//   emits the palette index and the screen coordinate. Transparent and
//   off-screen pixels are dropped here, so the palette lookup and the
//   framebuffer never see them.
//
// Ports
//   Clk, Reset            : rising-edge clock, asynchronous active-high reset
//   start                 : 1-cycle request. It is sampled only in IDLE.
//   sprite_base, pos_x/y,
//   spr_w/h, flip_h       : sprite descriptor, captured on start
//   rom_addr / rom_data   : ROM read port. Data returns 1 cycle after the address.
//   pix_valid/pix_ready   : output handshake. A pixel transfers on a cycle where
//                           pix_valid && pix_ready. While pix_valid is high and
//                           pix_ready is low, pix_index/pix_x/pix_y hold steady.
//                           pix_valid never drops without an accept.
//   pix_index, pix_x/y    : pixel payload
//   busy                  : high in FETCH, WAIT and OUT
//   done                  : 1-cycle pulse when the sprite is finished
//   dbg_state             : current FSM state (fetch_state_t encoding)
module dk_sprite_fetch
    import dk_gfx_pkg::*;
#(
    parameter int ROM_AW = 16,
    parameter int DIM_W  = 7
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ROM_AW-1:0] sprite_base,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [DIM_W-1:0]  spr_w,
    input  logic [DIM_W-1:0]  spr_h,
    input  logic              flip_h,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [3:0]        pix_index,
    output logic [9:0]        pix_x,
    output logic [9:0]        pix_y,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state
);

    fetch_state_t      state_q, state_d;
    logic [ROM_AW-1:0] base_q, base_d;
    logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
    logic              flip_q, flip_d;
    logic [DIM_W-1:0]  col_q, col_d, row_q, row_d;
    // Running row*spr_w. It grows by spr_w at each row wrap, so no multiplier is needed.
    logic [ROM_AW-1:0] row_base_q, row_base_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              pix_valid_q, pix_valid_d;
    pal_idx_t          pix_index_q, pix_index_d;
    logic [9:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              advance;
    logic              last_col, last_row;
    logic [10:0]       scr_x, scr_y;
    logic              skip;
    logic [DIM_W-1:0]  rom_col;

    // Screen coordinates use 11 bits so that a carry past 1023 is still clipped.
    assign scr_x    = {1'b0, pos_x_q} + 11'(col_q);
    assign scr_y    = {1'b0, pos_y_q} + 11'(row_q);
    assign skip     = (rom_data == TRANSPARENT_IDX) ||
                      (scr_x >= 11'(SCREEN_W)) || (scr_y >= 11'(SCREEN_H));
    assign last_col = (col_q == w_q - DIM_W'(1));
    assign last_row = (row_q == h_q - DIM_W'(1));

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        w_d         = w_q;
        h_d         = h_q;
        flip_d      = flip_q;
        col_d       = col_q;
        row_d       = row_q;
        row_base_d  = row_base_q;
        rom_addr_d  = rom_addr_q;
        pix_valid_d = pix_valid_q;
        pix_index_d = pix_index_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        advance     = 1'b0;
        rom_col     = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d     = sprite_base;
                    pos_x_d    = pos_x;
                    pos_y_d    = pos_y;
                    w_d        = spr_w;
                    h_d        = spr_h;
                    flip_d     = flip_h;
                    col_d      = '0;
                    row_d      = '0;
                    row_base_d = '0;
                    if (spr_w == '0 || spr_h == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_FETCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (skip) begin
                    advance = 1'b1;
                end else begin
                    state_d     = ST_OUT;
                    pix_valid_d = 1'b1;
                    pix_index_d = rom_data;
                    pix_x_d     = scr_x[9:0];
                    pix_y_d     = scr_y[9:0];
                end
            end
            ST_OUT: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    advance     = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (last_col) begin
                col_d      = '0;
                row_d      = row_q + DIM_W'(1);
                row_base_d = row_base_q + ROM_AW'(w_q);
            end else begin
                col_d = col_q + DIM_W'(1);
            end
            if (last_col && last_row) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                state_d = ST_FETCH;
            end
        end

        // The address register is loaded on entry to FETCH, so the ROM sees it during FETCH.
        if (state_d == ST_FETCH) begin
            rom_col    = flip_d ? (w_d - DIM_W'(1) - col_d) : col_d;
            rom_addr_d = base_d + row_base_d + ROM_AW'(rom_col);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            w_q         <= '0;
            h_q         <= '0;
            flip_q      <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            row_base_q  <= '0;
            rom_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_index_q <= '0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            w_q         <= w_d;
            h_q         <= h_d;
            flip_q      <= flip_d;
            col_q       <= col_d;
            row_q       <= row_d;
            row_base_q  <= row_base_d;
            rom_addr_q  <= rom_addr_d;
            pix_valid_q <= pix_valid_d;
            pix_index_q <= pix_index_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pix_valid = pix_valid_q;
    assign pix_index = pix_index_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dk_sprite_fetch.sv
module tb_dk_sprite_fetch;
    import dk_gfx_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] sprite_base = '0;
    logic [9:0]  pos_x = '0, pos_y = '0;
    logic [6:0]  spr_w = '0, spr_h = '0;
    logic        flip_h = 1'b0;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [3:0]  pix_index;
    logic [9:0]  pix_x, pix_y;
    logic        busy, done;
    logic [2:0]  dbg_state;

    logic [3:0]  rom_mem [1024];
    logic [23:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          pix_cnt = 0;
    int          done_cnt = 0;

    dk_sprite_fetch dut (
        .Clk(Clk), .Reset(Reset), .start(start), .sprite_base(sprite_base),
        .pos_x(pos_x), .pos_y(pos_y), .spr_w(spr_w), .spr_h(spr_h), .flip_h(flip_h),
        .rom_addr(rom_addr), .rom_data(rom_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_index(pix_index), .pix_x(pix_x), .pix_y(pix_y),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // clock / ROM model
    always #5 Clk = ~Clk;
    always @(posedge Clk) rom_data <= rom_mem[rom_addr[9:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard consumer: a pixel transfers on the next rising edge
    always @(negedge Clk) begin
        if (!Reset) begin
            if (done) done_cnt++;
            if (pix_valid && pix_ready) begin
                pix_cnt++;
                check("pix_expected_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0)
                    check("pix_payload", 64'({pix_index, pix_x, pix_y}), 64'(exp_q.pop_front()));
                check("pix_x_on_screen", 64'(pix_x < 10'd640), 64'd1);
                check("pix_y_on_screen", 64'(pix_y < 10'd480), 64'd1);
            end
        end
    end

    // reference walk of a sprite, pushing every pixel that should survive
    task automatic model_sprite(input int base, input int px, input int py,
                                input int w, input int h, input bit flip);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int        rc;
                int        x;
                int        y;
                logic [3:0] idx;
                logic [9:0] xl;
                logic [9:0] yl;
                rc  = flip ? (w - 1 - c) : c;
                idx = rom_mem[(base + r * w + rc) % 1024];
                x   = px + c;
                y   = py + r;
                xl  = x[9:0];
                yl  = y[9:0];
                if (idx != 4'd0 && x < 640 && y < 480) exp_q.push_back({idx, xl, yl});
            end
        end
    endtask

    // driver: present a descriptor and pulse start for one cycle
    task automatic start_sprite(input int base, input int px, input int py,
                                input int w, input int h, input bit flip);
        @(posedge Clk);
        #1;
        sprite_base = 16'(base);
        pos_x = 10'(px);
        pos_y = 10'(py);
        spr_w = 7'(w);
        spr_h = 7'(h);
        flip_h = flip;
        start = 1'b1;
        @(posedge Clk);
        #1;
        start = 1'b0;
    endtask

    // counts negedges from the first FETCH cycle until done is seen
    task automatic wait_done(input string tag, input int budget, output int cycles);
        bit found;
        found = 1'b0;
        cycles = 0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge Clk);
            if (done) found = 1'b1;
            else cycles++;
        end
        check({tag, "_done_seen"}, 64'(found), 64'd1);
    endtask

    task automatic run_sprite(input string tag, input int base, input int px, input int py,
                              input int w, input int h, input bit flip, input int exp_pix);
        int cyc;
        int p0;
        p0 = pix_cnt;
        model_sprite(base, px, py, w, h, flip);
        start_sprite(base, px, py, w, h, flip);
        wait_done(tag, w * h * 3 + 20, cyc);
        @(negedge Clk);
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_pix_count"}, 64'(pix_cnt - p0), 64'(exp_pix));
    endtask

    initial begin
        int cyc;
        int p0;
        int d0;
        bit hit;

        for (int i = 0; i < 1024; i++) rom_mem[i] = 4'd0;
        rom_mem[16'h10] = 4'd1; rom_mem[16'h11] = 4'd2; rom_mem[16'h12] = 4'd3; rom_mem[16'h13] = 4'd4;
        rom_mem[16'h20] = 4'd0; rom_mem[16'h21] = 4'd5; rom_mem[16'h22] = 4'd0;
        for (int i = 0; i < 4; i++) rom_mem[16'h30 + i] = 4'(i + 1);
        rom_mem[16'h40] = 4'd7; rom_mem[16'h41] = 4'd8; rom_mem[16'h42] = 4'd9;
        rom_mem[16'h50] = 4'd6;
        for (int i = 0; i < 16; i++) rom_mem[16'h60 + i] = 4'((i % 15) + 1);
        for (int i = 0; i < 15; i++) rom_mem[16'h100 + i] = 4'($urandom_range(0, 15));

        // reset values
        #12;
        check("reset_outputs", 64'({pix_valid, pix_index, pix_x, pix_y, busy, done, rom_addr}), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // 2x2 sprite: pixel order, address, busy, 12-cycle pixel walk
        model_sprite(16'h10, 10, 20, 2, 2, 1'b0);
        start_sprite(16'h10, 10, 20, 2, 2, 1'b0);
        @(negedge Clk);
        check("t1_first_fetch_state", 64'(dbg_state), 64'(ST_FETCH));
        check("t1_first_rom_addr", 64'(rom_addr), 64'h10);
        check("t1_busy_in_fetch", 64'(busy), 64'd1);
        wait_done("t1", 40, cyc);
        check("t1_fetch_to_done_cycles", 64'(cyc + 1), 64'd12);
        check("t1_busy_low_in_done", 64'(busy), 64'd0);
        @(negedge Clk);
        check("t1_done_one_cycle", 64'(done), 64'd0);
        check("t1_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t1_pix_count", 64'(pix_cnt), 64'd4);

        // transparent pixels skipped
        run_sprite("t2", 16'h20, 50, 60, 3, 1, 1'b0, 1);

        // right-edge clipping
        run_sprite("t3", 16'h30, 638, 5, 4, 1, 1'b0, 2);

        // horizontal flip
        run_sprite("t4", 16'h40, 100, 7, 3, 1, 1'b1, 3);

        // back-pressure: payload stable for 5 stalled cycles, then one accept
        pix_ready = 1'b0;
        p0 = pix_cnt;
        model_sprite(16'h50, 100, 100, 1, 1, 1'b0);
        start_sprite(16'h50, 100, 100, 1, 1, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge Clk);
            if (pix_valid) hit = 1'b1;
        end
        check("t5_valid_reached", 64'(hit), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge Clk);
            check("t5_stall_valid", 64'(pix_valid), 64'd1);
            if (exp_q.size() != 0)
                check("t5_stall_payload", 64'({pix_index, pix_x, pix_y}), 64'(exp_q[0]));
        end
        @(posedge Clk);
        #1;
        pix_ready = 1'b1;
        wait_done("t5", 20, cyc);
        check("t5_single_accept", 64'(pix_cnt - p0), 64'd1);
        check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // randomised sprite near the bottom-right corner
        begin
            int rx;
            int ry;
            int rf;
            int n;
            rx = $urandom_range(628, 639);
            ry = $urandom_range(470, 479);
            rf = $urandom_range(0, 1);
            p0 = pix_cnt;
            model_sprite(16'h100, rx, ry, 5, 3, rf[0]);
            n = exp_q.size();
            start_sprite(16'h100, rx, ry, 5, 3, rf[0]);
            wait_done("t_rand", 80, cyc);
            @(negedge Clk);
            check("t_rand_queue_empty", 64'(exp_q.size()), 64'd0);
            check("t_rand_pix_count", 64'(pix_cnt - p0), 64'(n));
        end

        // reset in WAIT of a 4x4 sprite
        model_sprite(16'h60, 200, 200, 4, 4, 1'b0);
        start_sprite(16'h60, 200, 200, 4, 4, 1'b0);
        hit = 1'b0;
        for (int c = 0; c < 10 && !hit; c++) begin
            @(negedge Clk);
            if (dbg_state == ST_WAIT) hit = 1'b1;
        end
        check("t6_wait_reached", 64'(hit), 64'd1);
        #1;
        Reset = 1'b1;
        #1;
        check("t6_reset_outputs", 64'({pix_valid, pix_index, pix_x, pix_y, busy, done, rom_addr}), 64'd0);
        check("t6_reset_state", 64'(dbg_state), 64'(ST_IDLE));
        exp_q.delete();
        p0 = pix_cnt;
        d0 = done_cnt;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        check("t6_no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        check("t6_no_pix_after_reset", 64'(pix_cnt - p0), 64'd0);
        run_sprite("t6_restart", 16'h10, 300, 400, 2, 2, 1'b0, 4);

        // zero-width sprite: done one cycle after start, nothing emitted
        p0 = pix_cnt;
        start_sprite(16'h10, 5, 5, 0, 3, 1'b0);
        @(negedge Clk);
        check("t7_done_immediate", 64'(done), 64'd1);
        check("t7_busy_low", 64'(busy), 64'd0);
        @(negedge Clk);
        check("t7_done_pulse_end", 64'(done), 64'd0);
        repeat (3) @(negedge Clk);
        check("t7_no_pixels", 64'(pix_cnt - p0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
